rotate_tile_sched: RTL and testbench
====================================

# rotate_tile_sched

Tile scheduler for the rotation engine: walks the source image in 8x8 pixel tiles and requests one DMA read burst and one DMA write burst per tile. It presents the pixel core with source and destination tile coordinates for the selected rotation, plus valid-pixel counts for partial edge tiles. It sits between the register front-end (start, stop, dimensions, degrees, direction) and the DMA and pixel-core pair, and reports completion or abort.

## Interface
- P_TILE, 8, tile edge in pixels; fixed power of two, log2 = 3
- P_DIM_W, 16, width of the image dimension inputs
- I_TS_HCLK  in  1  clock
- I_TS_HRESET_N  in  1  asynchronous active-low reset
- I_TS_START  in  1  start pulse; sampled in IDLE only
- I_TS_STOP  in  1  abort request; level, sampled every cycle
- I_TS_WIDTH  in  P_DIM_W  source width in pixels
- I_TS_HEIGHT  in  P_DIM_W  source height in pixels
- I_TS_DEGREES  in  2  0/90/180/270
- I_TS_DIRECTION  in  1  1 = counter-clockwise, 0 = clockwise
- I_TS_ACK  in  1  DMA accepted the current request
- I_TS_XFER_DONE  in  1  DMA finished the accepted burst
- O_TS_RD_REQ / O_TS_WR_REQ  out  1  read or write burst request
- O_TS_SRC_TX, O_TS_SRC_TY  out  13  source tile column and row
- O_TS_DST_TX, O_TS_DST_TY  out  13  destination tile column and row
- O_TS_VALID_W, O_TS_VALID_H  out  4  valid pixels in the current tile (1..8)
- O_TS_BUSY  out  1  high from the cycle after START until return to IDLE
- O_TS_DONE, O_TS_ABORTED  out  1  one-cycle completion or abort pulse
- O_TS_CYCLES  out  32  busy-cycle count (see Configuration)

## Operation
- On START in IDLE, the block snapshots width, height, degrees and direction.
- It normalises the rotation to a clockwise value k: k = DIRECTION ? (4-DEGREES)&3 : DEGREES.
- Tile counts use a 17-bit intermediate sum: NTX = (W+7)>>3, NTY = (H+7)>>3.
- Tiles are walked in raster order: TX runs 0..NTX-1 as the inner loop, TY runs 0..NTY-1 as the outer loop.
- Destination mapping for clockwise k:
  - k=0: (TX, TY)
  - k=1: (NTY-1-TY, TX)
  - k=2: (NTX-1-TX, NTY-1-TY)
  - k=3: (TY, NTX-1-TX)
- VALID_W = W[2:0] when TX = NTX-1 and W[2:0] != 0; otherwise 8. VALID_H follows the same rule using TY and H.
- States and transitions:
  - IDLE -> RD_REQ on START, or -> DONE on START when W or H is 0.
  - RD_REQ -> RD_WAIT on ACK.
  - RD_WAIT -> WR_REQ on XFER_DONE.
  - WR_REQ -> WR_WAIT on ACK.
  - WR_WAIT -> NEXT on XFER_DONE.
  - NEXT advances TX/TY, then goes -> RD_REQ, or -> DONE after the last tile.
  - DONE -> IDLE.
- RD_REQ and WR_REQ are registered. Each is high for the whole of its REQ state.
- Coordinates and valid counts stay stable from RD_REQ entry until NEXT.
- ACK and XFER_DONE are ignored outside their matching state.
- STOP handling:
  - In RD_REQ or WR_REQ, the request is dropped and the block goes to IDLE next cycle with an ABORTED pulse.
  - In a WAIT state, the block waits for XFER_DONE, then goes to IDLE with an ABORTED pulse.
  - STOP has priority over a same-cycle ACK.
  - On abort, DONE is never pulsed.
- START while BUSY is ignored.
- Asynchronous reset at any time returns the block to IDLE.
- Reset value of every output is 0, except VALID_W and VALID_H, which reset to 8.

## Timing
- START high in cycle N (IDLE): RD_REQ, BUSY and valid coordinates appear in N+1.
- ACK sampled in the same cycle as REQ high: REQ is low in the next cycle.
- XFER_DONE in RD_WAIT: WR_REQ is high in the next cycle.
- XFER_DONE in WR_WAIT: one NEXT cycle, then RD_REQ, so there are 2 cycles from XFER_DONE to the next read request.
- After the last tile's XFER_DONE: NEXT, then DONE (DONE pulse, BUSY still high), then IDLE with BUSY low.
- Zero dimension: START in cycle N, DONE pulse in N+1, no requests issued.

## Configuration
- ROTATE_TS_PERF_EN defined: a 32-bit counter clears on START and increments every BUSY cycle. It saturates at 0xFFFFFFFF and holds its value in IDLE.
- ROTATE_TS_PERF_EN undefined: O_TS_CYCLES is tied to 0 and no counter logic is built.

## Structure
- Package rotate_pkg holds:
  - the state enum
  - P_DEG_0/90/180/270
  - P_TILE and its log2
  - the tile-coordinate width (13)
- Sub-module rotate_tile_map holds the combinational mapping: (TX, TY, NTX, NTY, k) -> (DST_TX, DST_TY).

## Test plan
- W=16, H=8, deg 0, CW: reads at tiles (0,0) then (1,0), destinations identical, DONE after the 2nd write, VALID_W=8.
- W=24, H=16, 90 CW: the tile sequence yields destination (1,0) for (0,0) and (1,2) for (2,0). Repeating with deg 270, DIRECTION=1 gives an identical trace.
- W=20, H=12, 180: on TX=2, VALID_W=4; on TY=1, VALID_H=4; source (2,1) maps to destination (0,0).
- STOP asserted in RD_WAIT: the block waits for XFER_DONE, then ABORTED pulses, with no WR_REQ and no DONE. A fresh START afterwards restarts at tile (0,0).
- W=0, START: DONE in the next cycle and no RD_REQ. With ROTATE_TS_PERF_EN defined, O_TS_CYCLES = 1.
- Asynchronous reset asserted in WR_WAIT: all outputs go to their reset values immediately, and a late XFER_DONE is ignored.

Source files
------------

// File: rtl/rotate_pkg.sv
// Shared types and constants for the rotation engine tile scheduler.
package rotate_pkg;

  localparam int P_TILE      = 8;
  localparam int P_TILE_LOG2 = 3;
  localparam int P_COORD_W   = 13;

  localparam logic [1:0] P_DEG_0   = 2'd0;
  localparam logic [1:0] P_DEG_90  = 2'd1;
  localparam logic [1:0] P_DEG_180 = 2'd2;
  localparam logic [1:0] P_DEG_270 = 2'd3;

  typedef logic [P_COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

endpackage

// File: rtl/rotate_tile_map.sv
// Source tile to destination tile mapping for a clockwise quarter-turn count.
module rotate_tile_map
  import rotate_pkg::*;
(
  input  coord_t     tx,
  input  coord_t     ty,
  input  coord_t     ntx_m1,
  input  coord_t     nty_m1,
  input  logic [1:0] k,
  output coord_t     dst_tx,
  output coord_t     dst_ty
);

  always_comb begin
    dst_tx = tx;
    dst_ty = ty;
    unique case (k)
      P_DEG_0: begin
        dst_tx = tx;
        dst_ty = ty;
      end
      P_DEG_90: begin
        dst_tx = nty_m1 - ty;
        dst_ty = tx;
      end
      P_DEG_180: begin
        dst_tx = ntx_m1 - tx;
        dst_ty = nty_m1 - ty;
      end
      P_DEG_270: begin
        dst_tx = ty;
        dst_ty = ntx_m1 - tx;
      end
    endcase
  end

endmodule

// File: rtl/rotate_tile_sched.sv
// Tile scheduler: walks 8x8 tiles, issues DMA read/write bursts per tile.
// Optional busy-cycle counter built when ROTATE_TS_PERF_EN is defined.
module rotate_tile_sched
  import rotate_pkg::*;
#(
  parameter int P_DIM_W = 16
) (
  input  logic               I_TS_HCLK,
  input  logic               I_TS_HRESET_N,
  input  logic               I_TS_START,
  input  logic               I_TS_STOP,
  input  logic [P_DIM_W-1:0] I_TS_WIDTH,
  input  logic [P_DIM_W-1:0] I_TS_HEIGHT,
  input  logic [1:0]         I_TS_DEGREES,
  input  logic               I_TS_DIRECTION,
  input  logic               I_TS_ACK,
  input  logic               I_TS_XFER_DONE,
  output logic               O_TS_RD_REQ,
  output logic               O_TS_WR_REQ,
  output logic [12:0]        O_TS_SRC_TX,
  output logic [12:0]        O_TS_SRC_TY,
  output logic [12:0]        O_TS_DST_TX,
  output logic [12:0]        O_TS_DST_TY,
  output logic [3:0]         O_TS_VALID_W,
  output logic [3:0]         O_TS_VALID_H,
  output logic               O_TS_BUSY,
  output logic               O_TS_DONE,
  output logic               O_TS_ABORTED,
  output logic [31:0]        O_TS_CYCLES
);

  state_t     state;
  coord_t     tx;
  coord_t     ty;
  coord_t     ntx_m1;
  coord_t     nty_m1;
  logic [1:0] k;
  logic [2:0] w_rem;
  logic [2:0] h_rem;
  logic       stop_pend;
  logic       rd_req;
  logic       wr_req;
  logic       busy;
  logic       done;
  logic       aborted;

  logic [P_DIM_W:0] ntx_full;
  logic [P_DIM_W:0] nty_full;
  logic             dim_zero;
  logic [1:0]       k_in;
  logic             last_tx;
  logic             last_ty;

  assign ntx_full = ({1'b0, I_TS_WIDTH} + (P_DIM_W+1)'(P_TILE - 1))
                    >> P_TILE_LOG2;
  assign nty_full = ({1'b0, I_TS_HEIGHT} + (P_DIM_W+1)'(P_TILE - 1))
                    >> P_TILE_LOG2;
  assign dim_zero = (I_TS_WIDTH == '0) || (I_TS_HEIGHT == '0);
  assign k_in     = I_TS_DIRECTION ? 2'd0 - I_TS_DEGREES : I_TS_DEGREES;
  assign last_tx  = (tx == ntx_m1);
  assign last_ty  = (ty == nty_m1);

  always_ff @(posedge I_TS_HCLK or negedge I_TS_HRESET_N) begin
    if (!I_TS_HRESET_N) begin
      state     <= S_IDLE;
      tx        <= '0;
      ty        <= '0;
      ntx_m1    <= '0;
      nty_m1    <= '0;
      k         <= '0;
      w_rem     <= '0;
      h_rem     <= '0;
      stop_pend <= 1'b0;
      rd_req    <= 1'b0;
      wr_req    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        S_IDLE: begin
          if (I_TS_START) begin
            tx        <= '0;
            ty        <= '0;
            ntx_m1    <= coord_t'(ntx_full - (P_DIM_W+1)'(1));
            nty_m1    <= coord_t'(nty_full - (P_DIM_W+1)'(1));
            k         <= k_in;
            w_rem     <= I_TS_WIDTH[P_TILE_LOG2-1:0];
            h_rem     <= I_TS_HEIGHT[P_TILE_LOG2-1:0];
            stop_pend <= 1'b0;
            busy      <= 1'b1;
            if (dim_zero) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state  <= S_RD_REQ;
              rd_req <= 1'b1;
            end
          end
        end
        S_RD_REQ: begin
          if (I_TS_STOP) begin
            rd_req  <= 1'b0;
            busy    <= 1'b0;
            aborted <= 1'b1;
            state   <= S_IDLE;
          end else if (I_TS_ACK) begin
            rd_req <= 1'b0;
            state  <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          // A stop seen mid-burst is remembered until the burst drains
          if (I_TS_XFER_DONE) begin
            if (I_TS_STOP || stop_pend) begin
              busy    <= 1'b0;
              aborted <= 1'b1;
              state   <= S_IDLE;
            end else begin
              wr_req <= 1'b1;
              state  <= S_WR_REQ;
            end
          end else if (I_TS_STOP) begin
            stop_pend <= 1'b1;
          end
        end
        S_WR_REQ: begin
          if (I_TS_STOP) begin
            wr_req  <= 1'b0;
            busy    <= 1'b0;
            aborted <= 1'b1;
            state   <= S_IDLE;
          end else if (I_TS_ACK) begin
            wr_req <= 1'b0;
            state  <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (I_TS_XFER_DONE) begin
            if (I_TS_STOP || stop_pend) begin
              busy    <= 1'b0;
              aborted <= 1'b1;
              state   <= S_IDLE;
            end else begin
              state <= S_NEXT;
            end
          end else if (I_TS_STOP) begin
            stop_pend <= 1'b1;
          end
        end
        S_NEXT: begin
          if (I_TS_STOP) begin
            busy    <= 1'b0;
            aborted <= 1'b1;
            state   <= S_IDLE;
          end else if (last_tx && last_ty) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            if (last_tx) begin
              tx <= '0;
              ty <= ty + coord_t'(1);
            end else begin
              tx <= tx + coord_t'(1);
            end
            rd_req <= 1'b1;
            state  <= S_RD_REQ;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          rd_req <= 1'b0;
          wr_req <= 1'b0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  rotate_tile_map u_map (
    .tx     (tx),
    .ty     (ty),
    .ntx_m1 (ntx_m1),
    .nty_m1 (nty_m1),
    .k      (k),
    .dst_tx (O_TS_DST_TX),
    .dst_ty (O_TS_DST_TY)
  );

  assign O_TS_RD_REQ  = rd_req;
  assign O_TS_WR_REQ  = wr_req;
  assign O_TS_SRC_TX  = tx;
  assign O_TS_SRC_TY  = ty;
  assign O_TS_BUSY    = busy;
  assign O_TS_DONE    = done;
  assign O_TS_ABORTED = aborted;
  assign O_TS_VALID_W = (last_tx && w_rem != '0) ? {1'b0, w_rem}
                                                : 4'(P_TILE);
  assign O_TS_VALID_H = (last_ty && h_rem != '0) ? {1'b0, h_rem}
                                                : 4'(P_TILE);

`ifdef ROTATE_TS_PERF_EN
  logic [31:0] cycles;

  always_ff @(posedge I_TS_HCLK or negedge I_TS_HRESET_N) begin
    if (!I_TS_HRESET_N) begin
      cycles <= '0;
    end else if (state == S_IDLE && I_TS_START) begin
      cycles <= '0;
    end else if (busy && cycles != '1) begin
      cycles <= cycles + 32'd1;
    end
  end

  assign O_TS_CYCLES = cycles;
`else
  assign O_TS_CYCLES = '0;
`endif

endmodule

// File: tb/tb_rotate_tile_sched.sv
// Randomised bench for rotate_tile_sched against a tile-list model.
module tb_rotate_tile_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] width = '0;
  logic [15:0] height = '0;
  logic [1:0]  deg = '0;
  logic        dir = 1'b0;
  logic        ack = 1'b0;
  logic        xfer = 1'b0;

  logic        rd_req, wr_req, busy, done, aborted;
  logic [12:0] src_tx, src_ty, dst_tx, dst_ty;
  logic [3:0]  valid_w, valid_h;
  logic [31:0] cycles;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int sx; int sy; int dx; int dy; int vw; int vh;
  } tile_t;

  rotate_tile_sched dut (
    .I_TS_HCLK      (clk),
    .I_TS_HRESET_N  (rst_n),
    .I_TS_START     (start),
    .I_TS_STOP      (stop),
    .I_TS_WIDTH     (width),
    .I_TS_HEIGHT    (height),
    .I_TS_DEGREES   (deg),
    .I_TS_DIRECTION (dir),
    .I_TS_ACK       (ack),
    .I_TS_XFER_DONE (xfer),
    .O_TS_RD_REQ    (rd_req),
    .O_TS_WR_REQ    (wr_req),
    .O_TS_SRC_TX    (src_tx),
    .O_TS_SRC_TY    (src_ty),
    .O_TS_DST_TX    (dst_tx),
    .O_TS_DST_TY    (dst_ty),
    .O_TS_VALID_W   (valid_w),
    .O_TS_VALID_H   (valid_h),
    .O_TS_BUSY      (busy),
    .O_TS_DONE      (done),
    .O_TS_ABORTED   (aborted),
    .O_TS_CYCLES    (cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [96:0] obs_vec();
    return {rd_req, wr_req, busy, done, aborted,
            src_tx, src_ty, dst_tx, dst_ty,
            valid_w, valid_h, cycles};
  endfunction

  // Tile list: raster walk, destination by repeated 90-degree grid turns
  function automatic void build_model(input int w, input int h,
                                      input int dg, input int dr,
                                      output tile_t q[$]);
    int ntx, nty, k, x, y, gx, gy, t;
    tile_t e;
    q = {};
    ntx = (w + 7) / 8;
    nty = (h + 7) / 8;
    k = dr ? (4 - dg) % 4 : dg;
    for (int ty = 0; ty < nty; ty++) begin
      for (int tx = 0; tx < ntx; tx++) begin
        x = tx; y = ty; gx = ntx; gy = nty;
        for (int r = 0; r < k; r++) begin
          t = x;
          x = gy - 1 - y;
          y = t;
          t = gx; gx = gy; gy = t;
        end
        e.sx = tx; e.sy = ty; e.dx = x; e.dy = y;
        e.vw = (w - 8 * tx) < 8 ? (w - 8 * tx) : 8;
        e.vh = (h - 8 * ty) < 8 ? (h - 8 * ty) : 8;
        q.push_back(e);
      end
    end
  endfunction

  task automatic test_reset();
    logic [96:0] exp_v;
    exp_v = {5'b0, 52'b0, 4'd8, 4'd8, 32'd0};
    rst_n = 1'b0;
    #12;
    checks++;
    if (obs_vec() !== exp_v) begin
      errors++;
      $display("FAIL reset_hold got %h want %h", obs_vec(), exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_vec() !== exp_v) begin
      errors++;
      $display("FAIL reset_idle got %h want %h", obs_vec(), exp_v);
    end
  endtask

  task automatic test_jobs();
    int dw[5]   = '{16, 24, 24, 20, 20};
    int dh[5]   = '{8, 16, 16, 12, 12};
    int ddeg[5] = '{0, 1, 3, 2, 2};
    int ddir[5] = '{0, 0, 1, 0, 1};
    int w, h, dg, dr, d, c1, c2, exp_c;
    bit bad;
    tile_t q[$];
    tile_t e;
    for (int j = 0; j < 25; j++) begin
      if (j < 5) begin
        w = dw[j]; h = dh[j]; dg = ddeg[j]; dr = ddir[j];
      end else begin
        w = (j % 5 == 0) ? $urandom_range(1, 100) : $urandom_range(1, 40);
        h = (j % 5 == 0) ? $urandom_range(1, 16) : $urandom_range(1, 40);
        dg = $urandom_range(0, 3);
        dr = $urandom_range(0, 1);
      end
      build_model(w, h, dg, dr, q);
      width = 16'(w); height = 16'(h); deg = 2'(dg); dir = dr[0];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c1 = cyc;
      // inputs are snapshotted; scramble them for the rest of the job
      width = 16'($urandom); height = 16'($urandom);
      deg = 2'($urandom); dir = 1'($urandom);
      bad = 1'b0;
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        checks++;
        if ({rd_req, wr_req, busy} !== 3'b101) begin
          errors++; bad = 1'b1;
          $display("FAIL rd_req job%0d tile%0d got rd/wr/busy %b want 101",
                   j, i, {rd_req, wr_req, busy});
          break;
        end
        checks++;
        if ({src_tx, src_ty, dst_tx, dst_ty, valid_w, valid_h} !==
            {13'(e.sx), 13'(e.sy), 13'(e.dx), 13'(e.dy),
             4'(e.vw), 4'(e.vh)}) begin
          errors++;
          $display("FAIL tile job%0d w%0d h%0d k%0d/%0d got s(%0d,%0d) d(%0d,%0d) v(%0d,%0d) want s(%0d,%0d) d(%0d,%0d) v(%0d,%0d)",
                   j, w, h, dg, dr, src_tx, src_ty, dst_tx, dst_ty,
                   valid_w, valid_h, e.sx, e.sy, e.dx, e.dy, e.vw, e.vh);
        end
        d = $urandom_range(0, 2);
        repeat (d) begin
          xfer = 1'($urandom); start = 1'($urandom);
          @(negedge clk);
          xfer = 1'b0; start = 1'b0;
          checks++;
          if (rd_req !== 1'b1) begin
            errors++;
            $display("FAIL rd_hold job%0d got %b want 1", j, rd_req);
          end
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if ({rd_req, wr_req} !== 2'b00) begin
          errors++;
          $display("FAIL rd_ack job%0d got rd/wr %b want 00", j, {rd_req, wr_req});
        end
        d = $urandom_range(0, 3);
        repeat (d) begin
          ack = 1'($urandom);
          @(negedge clk);
          ack = 1'b0;
          checks++;
          if ({rd_req, wr_req} !== 2'b00) begin
            errors++;
            $display("FAIL rd_wait job%0d got rd/wr %b want 00", j, {rd_req, wr_req});
          end
        end
        xfer = 1'b1;
        @(negedge clk);
        xfer = 1'b0;
        checks++;
        if ({rd_req, wr_req, src_tx, src_ty} !==
            {2'b01, 13'(e.sx), 13'(e.sy)}) begin
          errors++; bad = 1'b1;
          $display("FAIL wr_req job%0d got rd/wr %b s(%0d,%0d) want 01 s(%0d,%0d)",
                   j, {rd_req, wr_req}, src_tx, src_ty, e.sx, e.sy);
          break;
        end
        d = $urandom_range(0, 2);
        repeat (d) begin
          xfer = 1'($urandom);
          @(negedge clk);
          xfer = 1'b0;
          checks++;
          if (wr_req !== 1'b1) begin
            errors++;
            $display("FAIL wr_hold job%0d got %b want 1", j, wr_req);
          end
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if ({rd_req, wr_req} !== 2'b00) begin
          errors++;
          $display("FAIL wr_ack job%0d got rd/wr %b want 00", j, {rd_req, wr_req});
        end
        d = $urandom_range(0, 3);
        repeat (d) begin
          ack = 1'($urandom);
          @(negedge clk);
          ack = 1'b0;
        end
        xfer = 1'b1;
        @(negedge clk);
        xfer = 1'b0;
        checks++;
        if ({rd_req, wr_req, done, busy} !== 4'b0001) begin
          errors++;
          $display("FAIL next job%0d got rd/wr/done/busy %b want 0001",
                   j, {rd_req, wr_req, done, busy});
        end
        @(negedge clk);
      end
      if (bad) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        continue;
      end
      c2 = cyc;
      checks++;
      if ({done, busy, rd_req, wr_req} !== 4'b1100) begin
        errors++;
        $display("FAIL done job%0d got done/busy/rd/wr %b want 1100",
                 j, {done, busy, rd_req, wr_req});
      end
      @(negedge clk);
`ifdef ROTATE_TS_PERF_EN
      exp_c = c2 - c1 + 1;
`else
      exp_c = 0;
`endif
      checks++;
      if ({done, busy, rd_req, cycles} !== {3'b000, 32'(exp_c)}) begin
        errors++;
        $display("FAIL idle job%0d got done/busy/rd %b cycles %0d want 000 %0d",
                 j, {done, busy, rd_req}, cycles, exp_c);
      end
    end
  endtask

  task automatic test_zero();
    int exp_c;
`ifdef ROTATE_TS_PERF_EN
    exp_c = 1;
`else
    exp_c = 0;
`endif
    for (int i = 0; i < 2; i++) begin
      width = (i == 0) ? 16'd0 : 16'd9;
      height = (i == 0) ? 16'd9 : 16'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({done, rd_req, wr_req, busy} !== 4'b1001) begin
        errors++;
        $display("FAIL zero_done%0d got done/rd/wr/busy %b want 1001",
                 i, {done, rd_req, wr_req, busy});
      end
      @(negedge clk);
      checks++;
      if ({done, rd_req, busy, cycles} !== {3'b000, 32'(exp_c)}) begin
        errors++;
        $display("FAIL zero_idle%0d got done/rd/busy %b cycles %0d want 000 %0d",
                 i, {done, rd_req, busy}, cycles, exp_c);
      end
    end
  endtask

  task automatic test_stop();
    width = 16'd16; height = 16'd16; deg = 2'd0; dir = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ack = 1'b1; @(negedge clk); ack = 1'b0;
    xfer = 1'b1; @(negedge clk); xfer = 1'b0;
    ack = 1'b1; @(negedge clk); ack = 1'b0;
    xfer = 1'b1; @(negedge clk); xfer = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_req, src_tx, src_ty} !== {1'b1, 13'd1, 13'd0}) begin
      errors++;
      $display("FAIL stop_tile1 got rd %b s(%0d,%0d) want 1 s(1,0)",
               rd_req, src_tx, src_ty);
    end
    ack = 1'b1; @(negedge clk); ack = 1'b0;
    stop = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({wr_req, busy, aborted, done} !== 4'b0100) begin
        errors++;
        $display("FAIL stop_wait got wr/busy/abort/done %b want 0100",
                 {wr_req, busy, aborted, done});
      end
    end
    xfer = 1'b1;
    @(negedge clk);
    xfer = 1'b0; stop = 1'b0;
    checks++;
    if ({aborted, done, wr_req, rd_req, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL stop_abort got abort/done/wr/rd/busy %b want 10000",
               {aborted, done, wr_req, rd_req, busy});
    end
    @(negedge clk);
    checks++;
    if ({aborted, done, busy, wr_req} !== 4'b0000) begin
      errors++;
      $display("FAIL stop_after got abort/done/busy/wr %b want 0000",
               {aborted, done, busy, wr_req});
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({rd_req, busy, src_tx, src_ty} !== {2'b11, 13'd0, 13'd0}) begin
      errors++;
      $display("FAIL stop_restart got rd/busy %b s(%0d,%0d) want 11 s(0,0)",
               {rd_req, busy}, src_tx, src_ty);
    end
    stop = 1'b1; ack = 1'b1;
    @(negedge clk);
    stop = 1'b0; ack = 1'b0;
    checks++;
    if ({rd_req, aborted, busy, done} !== 4'b0100) begin
      errors++;
      $display("FAIL stop_req got rd/abort/busy/done %b want 0100",
               {rd_req, aborted, busy, done});
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [96:0] exp_v;
    exp_v = {5'b0, 52'b0, 4'd8, 4'd8, 32'd0};
    width = 16'd20; height = 16'd12; deg = 2'd2; dir = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ack = 1'b1; @(negedge clk); ack = 1'b0;
    xfer = 1'b1; @(negedge clk); xfer = 1'b0;
    ack = 1'b1; @(negedge clk); ack = 1'b0;
    checks++;
    if ({busy, wr_req, dst_tx, dst_ty} !== {2'b10, 13'd2, 13'd1}) begin
      errors++;
      $display("FAIL arst_pre got busy/wr %b d(%0d,%0d) want 10 d(2,1)",
               {busy, wr_req}, dst_tx, dst_ty);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== exp_v) begin
      errors++;
      $display("FAIL arst_now got %h want %h", obs_vec(), exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    xfer = 1'b1;
    @(negedge clk);
    xfer = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_vec() !== exp_v) begin
      errors++;
      $display("FAIL arst_late_xfer got %h want %h", obs_vec(), exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_jobs();
    test_zero();
    test_stop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
